// File: rtl/button_input_debounce.sv
// Four-channel push-button conditioner: 2-flop synchronizer, debounce FSM,
// and one-cycle press/release/long-press event pulses per button.
module button_input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_long
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

  typedef enum logic [1:0] {
    UP       = 2'd0,
    DEB_DOWN = 2'd1,
    DOWN     = 2'd2,
    DEB_UP   = 2'd3
  } state_e;

  logic [3:0]    sync1_q, sync2_q, sync1_d;
  state_e        state_q [4];
  state_e        state_d [4];
  logic [DW-1:0] deb_q   [4];
  logic [DW-1:0] deb_d   [4];
  logic [HW-1:0] hold_q  [4];
  logic [HW-1:0] hold_d  [4];
  logic [3:0]    press_q, press_d;
  logic [3:0]    release_q, release_d;
  logic [3:0]    long_q, long_d;
  logic [3:0]    level;

  assign sync1_d = (ACTIVE_LOW != 0) ? ~btn_n : btn_n;

  // The accepted level is implied by the state: pressed in DOWN and DEB_UP.
  always_comb begin
    level = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      level[i] = (state_q[i] == DOWN) || (state_q[i] == DEB_UP);
    end
  end

  always_comb begin
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      deb_d[i]   = '0;
      hold_d[i]  = hold_q[i];

      if (sync2_q[i] == level[i]) begin
        state_d[i] = level[i] ? DOWN : UP;
      end else if (deb_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        state_d[i]   = level[i] ? UP : DOWN;
        press_d[i]   = ~level[i];
        release_d[i] = level[i];
      end else begin
        deb_d[i]   = deb_q[i] + 1'b1;
        state_d[i] = level[i] ? DEB_UP : DEB_DOWN;
      end

      if (!level[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != HW'(LONG_CYCLES)) begin
        hold_d[i] = hold_q[i] + 1'b1;
      end
      long_d[i] = level[i] && (hold_q[i] != HW'(LONG_CYCLES)) &&
                  (hold_d[i] == HW'(LONG_CYCLES));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= UP;
        deb_q[i]   <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync1_q;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        deb_q[i]   <= deb_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  assign btn_level   = level;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: tb/tb_button_input_debounce.sv
// Bench for button_input_debounce: directed scenarios plus random button
// activity, all compared against a cycle-level behavioural model.
module tb_button_input_debounce;

  localparam int D = 4;
  localparam int L = 16;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;

  button_input_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [3:0] m_lvl, e_press, e_rel, e_long, s1, s2;
  int         mism   [4];
  int         rise_t [4];
  int         edge_no = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_lvl = '0; e_press = '0; e_rel = '0; e_long = '0; s1 = '0; s2 = '0;
    for (int i = 0; i < 4; i++) begin
      mism[i] = 0;
      rise_t[i] = 0;
    end
  endtask

  // One rising edge: the logic sees raw values from two edges earlier; a
  // level flips after D consecutive disagreeing samples; a long press fires
  // L edges after the rise if the level was still high.
  task automatic model_edge();
    logic synced, prev;
    edge_no++;
    if (rst) begin
      model_clear();
      return;
    end
    e_press = '0; e_rel = '0; e_long = '0;
    for (int i = 0; i < 4; i++) begin
      synced = s2[i];
      s2[i]  = s1[i];
      s1[i]  = ~btn_n[i];
      prev   = m_lvl[i];
      if (synced != m_lvl[i]) begin
        mism[i]++;
        if (mism[i] == D) begin
          mism[i]  = 0;
          m_lvl[i] = ~m_lvl[i];
          if (m_lvl[i]) begin
            e_press[i] = 1'b1;
            rise_t[i]  = edge_no;
          end else begin
            e_rel[i] = 1'b1;
          end
        end
      end else begin
        mism[i] = 0;
      end
      if (prev && (edge_no - rise_t[i] == L)) e_long[i] = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "_level"},   btn_level,   m_lvl);
    check_eq({tag, "_press"},   btn_press,   e_press);
    check_eq({tag, "_release"}, btn_release, e_rel);
    check_eq({tag, "_long"},    btn_long,    e_long);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all("cyc");
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    model_clear();
    #1;
    check_eq("rst_imm_level",   btn_level,   4'h0);
    check_eq("rst_imm_press",   btn_press,   4'h0);
    check_eq("rst_imm_release", btn_release, 4'h0);
    check_eq("rst_imm_long",    btn_long,    4'h0);
  endtask

  int pe, le, lc, re, pc, rc;
  logic [3:0] ev;

  initial begin
    rst = 1'b1;
    btn_n = '1;
    model_clear();
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    // Single press on bit 0
    btn_n = 4'b1110;
    pe = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (btn_press[0] && pe == 0) pe = e;
    end
    check_eq("press0_edge", pe, 6);
    btn_n = '1;
    repeat (12) step();

    // Three-cycle glitch on bit 1
    ev = '0;
    btn_n[1] = 1'b0;
    repeat (3) begin
      step();
      ev |= btn_press | btn_release | btn_long | btn_level;
    end
    btn_n[1] = 1'b1;
    repeat (12) begin
      step();
      ev |= btn_press | btn_release | btn_long | btn_level;
    end
    check_eq("glitch1_quiet", ev, 4'h0);

    // Long hold on bit 2
    btn_n[2] = 1'b0;
    pe = 0; le = 0; lc = 0; re = 0;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (btn_press[2] && pe == 0) pe = e;
      if (btn_long[2]) begin
        lc++;
        if (le == 0) le = e;
      end
    end
    btn_n[2] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (btn_release[2] && re == 0) re = e;
      if (btn_long[2]) lc++;
    end
    check_eq("hold2_press_edge",   pe, 6);
    check_eq("hold2_long_edge",    le, 22);
    check_eq("hold2_long_count",   lc, 1);
    check_eq("hold2_release_edge", re, 6);

    // All four together
    btn_n = 4'b0000;
    pc = 0;
    repeat (12) begin
      step();
      if (btn_press == 4'hF) pc++;
    end
    btn_n = 4'b1111;
    rc = 0;
    repeat (12) begin
      step();
      if (btn_release == 4'hF) rc++;
    end
    check_eq("all_press_once",   pc, 1);
    check_eq("all_release_once", rc, 1);

    // Reset during bit-0 debounce count 3 and bit-1 hold count 10
    btn_n[1] = 1'b0;
    repeat (11) step();
    btn_n[0] = 1'b0;
    repeat (5) step();
    check_eq("pre_rst_level", btn_level, 4'b0010);
    assert_rst();
    btn_n = '1;
    repeat (3) step();
    rst = 1'b0;
    ev = '0;
    repeat (30) begin
      step();
      ev |= btn_press | btn_release | btn_long | btn_level;
    end
    check_eq("post_rst_quiet", ev, 4'h0);

    // Button held through reset release
    btn_n[0] = 1'b0;
    assert_rst();
    repeat (3) step();
    rst = 1'b0;
    pe = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (btn_press[0] && pe == 0) pe = e;
    end
    check_eq("held_thru_rst_edge", pe, 6);
    btn_n = '1;
    repeat (12) step();

    // Random activity with occasional resets
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 9) == 0) btn_n[b] = ~btn_n[b];
      end
      if ($urandom_range(0, 299) == 0) begin
        assert_rst();
        repeat (2) step();
        rst = 1'b0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
